// File: rtl/uart_tx_fifo_if.sv
// CPU-side register/bus bundle for uart_tx_fifo: byte and divisor writes in, FIFO/FSM status out.
interface uart_tx_fifo_if;
  logic        data_we;
  logic [7:0]  data_in;
  logic        div_we;
  logic [15:0] div_in;
  logic        fifo_full;
  logic        fifo_empty;
  logic        busy;
  logic        overflow;

  modport master (
    output data_we, data_in, div_we, div_in,
    input  fifo_full, fifo_empty, busy, overflow
  );

  modport slave (
    input  data_we, data_in, div_we, div_in,
    output fifo_full, fifo_empty, busy, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter with a programmable baud divisor.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int DEPTH   = 16,
  parameter int DIV_RST = 433
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_fifo_if.slave bus,
  output logic          tx,
  output logic          frame_done,
  output logic [7:0]    frame_byte
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [15:0]   DIV_INIT = 16'(DIV_RST);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          fifo_full_r;
  logic          fifo_empty_r;
  logic          overflow_r;
  logic          push_s;
  logic          pop_s;
  logic          bit_end_s;
  logic [7:0]    head_s;

  state_t        state_r;
  logic [15:0]   div_r;
  logic [15:0]   div_lat_r;
  logic [15:0]   cnt_r;
  logic [7:0]    shift_r;
  logic [7:0]    byte_r;
  logic [2:0]    idx_r;
  logic          tx_r;
  logic          busy_r;
  logic          frame_done_r;
  logic [7:0]    frame_byte_r;

  // Push/pop decisions and next FIFO occupancy; full is judged before any same-cycle pop.
  always_comb begin
    push_s    = bus.data_we && !fifo_full_r;
    bit_end_s = (cnt_r == div_lat_r);
    head_s    = mem_r[rd_ptr_r];
    pop_s     = 1'b0;
    if (!fifo_empty_r) begin
      if (state_r == IDLE) begin
        pop_s = 1'b1;
      end else if ((state_r == STOP) && bit_end_s) begin
        pop_s = 1'b1;
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      pop_s = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO pointers, occupancy and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      fifo_full_r  <= 1'b0;
      fifo_empty_r <= 1'b1;
      overflow_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r      <= count_next_s;
      fifo_full_r  <= (count_next_s == FULL_CNT);
      fifo_empty_r <= (count_next_s == {CW{1'b0}});
      overflow_r   <= bus.data_we && fifo_full_r;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.data_in;
    end
  end

  // Software-visible divisor; an in-flight frame keeps its own latched copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= DIV_INIT;
    end else if (bus.div_we) begin
      div_r <= bus.div_in;
    end
  end

  // Transmit FSM: every output is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      div_lat_r    <= DIV_INIT;
      cnt_r        <= 16'd0;
      shift_r      <= 8'd0;
      byte_r       <= 8'd0;
      idx_r        <= 3'd0;
      tx_r         <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      frame_byte_r <= 8'd0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= 16'd0;
          if (pop_s) begin
            shift_r   <= head_s;
            byte_r    <= head_s;
            div_lat_r <= div_r;
            tx_r      <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= START;
          end else begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        START: begin
          if (bit_end_s) begin
            cnt_r   <= 16'd0;
            idx_r   <= 3'd0;
            tx_r    <= shift_r[0];
            state_r <= DATA;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            cnt_r <= 16'd0;
            if (idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_r    <= parity8(byte_r);
              state_r <= PARITY;
`else
              tx_r    <= 1'b1;
              state_r <= STOP;
`endif
            end else begin
              shift_r <= {1'b0, shift_r[7:1]};
              tx_r    <= shift_r[1];
              idx_r   <= idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end_s) begin
            cnt_r   <= 16'd0;
            tx_r    <= 1'b1;
            state_r <= STOP;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
`endif
        STOP: begin
          if (bit_end_s) begin
            cnt_r        <= 16'd0;
            frame_done_r <= 1'b1;
            frame_byte_r <= byte_r;
            if (pop_s) begin
              // Back-to-back: next frame starts with no idle bit in between.
              shift_r   <= head_s;
              byte_r    <= head_s;
              div_lat_r <= div_r;
              tx_r      <= 1'b0;
              state_r   <= START;
            end else begin
              tx_r    <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          cnt_r   <= 16'd0;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.fifo_full  = fifo_full_r;
  assign bus.fifo_empty = fifo_empty_r;
  assign bus.busy       = busy_r;
  assign bus.overflow   = overflow_r;
  assign tx             = tx_r;
  assign frame_done     = frame_done_r;
  assign frame_byte     = frame_byte_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: line waveforms, FIFO flags and a frame_byte scoreboard.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic       tx;
  logic       frame_done;
  logic [7:0] frame_byte;

  int n_checks;
  int n_errors;
  logic [7:0] exp_q[$];

  uart_tx_fifo_if ifc ();

  uart_tx_fifo #(.DEPTH(16), .DIV_RST(433)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifc),
    .tx         (tx),
    .frame_done (frame_done),
    .frame_byte (frame_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level at clock j of a frame: start, 8 data LSB first, optional parity, stop.
  function automatic logic exp_bit(input logic [7:0] b, input int divp1, input int j);
    int p;
    p = j / divp1;
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
`ifdef UART_TX_PARITY_EN
    if (p == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Scoreboard: every completed frame must match the oldest accepted byte.
  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      if (exp_q.size() == 0) check("sb_unexpected_frame", 128'(exp_q.size()), 128'd1);
      else check("sb_frame_byte", 128'(frame_byte), 128'(exp_q.pop_front()));
    end
  end

  task automatic push_byte(input logic [7:0] b, input bit expected);
    @(negedge clk);
    ifc.data_we = 1'b1;
    ifc.data_in = b;
    if (expected) exp_q.push_back(b);
    @(negedge clk);
    ifc.data_we = 1'b0;
  endtask

  task automatic set_div(input logic [15:0] d);
    @(negedge clk);
    ifc.div_we = 1'b1;
    ifc.div_in = d;
    @(negedge clk);
    ifc.div_we = 1'b0;
  endtask

  task automatic send_and_check(input logic [7:0] b, input int divp1, input string tag);
    logic [127:0] cap;
    logic [127:0] exp;
    logic [127:0] fd;
    int len;
    len = NBITS * divp1;
    cap = '0;
    exp = '0;
    fd  = '0;
    push_byte(b, 1'b1);
    check({tag, "_empty_after_write"}, 128'(ifc.fifo_empty), 128'd0);
    check({tag, "_tx_before_start"}, 128'(tx), 128'd1);
    for (int i = 0; i < len + 2; i++) begin
      @(negedge clk);
      if (i < len) begin
        cap[i] = tx;
        exp[i] = exp_bit(b, divp1, i);
      end
      fd[i] = frame_done;
    end
    check({tag, "_wave"}, cap, exp);
    check({tag, "_done_timing"}, fd, 128'd1 << len);
    check({tag, "_busy_after"}, 128'(ifc.busy), 128'd0);
  endtask

  initial begin
    int bad;
    int fd_seen;
    int first_t;
    int last_t;
    int gaps;
    int cyc;
    logic [127:0] cap_a;
    logic [127:0] cap_b;
    logic [127:0] exp_a;
    logic [127:0] exp_b;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    ifc.data_we = 1'b0;
    ifc.data_in = 8'd0;
    ifc.div_we  = 1'b0;
    ifc.div_in  = 16'd0;

    // Reset values, then 50 quiet cycles.
    repeat (3) @(negedge clk);
    check("rst_tx", 128'(tx), 128'd1);
    check("rst_busy", 128'(ifc.busy), 128'd0);
    check("rst_empty", 128'(ifc.fifo_empty), 128'd1);
    check("rst_full", 128'(ifc.fifo_full), 128'd0);
    check("rst_overflow", 128'(ifc.overflow), 128'd0);
    check("rst_frame_done", 128'(frame_done), 128'd0);
    check("rst_frame_byte", 128'(frame_byte), 128'd0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || ifc.fifo_empty !== 1'b1 || ifc.busy !== 1'b0) bad++;
    end
    check("idle_bad_cycles", 128'(bad), 128'd0);

    // Single byte with div=3.
    set_div(16'd3);
    send_and_check(8'hA5, 4, "a5_div3");

    // Burst of 17 bytes at div=433, 18th write overflows.
    set_div(16'd433);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      ifc.data_we = 1'b1;
      ifc.data_in = 8'(i);
      exp_q.push_back(8'(i));
    end
    @(negedge clk);
    check("burst_full", 128'(ifc.fifo_full), 128'd1);
    check("burst_no_overflow_yet", 128'(ifc.overflow), 128'd0);
    ifc.data_in = 8'hEE;
    @(negedge clk);
    ifc.data_we = 1'b0;
    check("overflow_pulse", 128'(ifc.overflow), 128'd1);
    @(negedge clk);
    check("overflow_one_cycle", 128'(ifc.overflow), 128'd0);
    fd_seen = 0;
    first_t = 0;
    last_t  = 0;
    gaps    = 0;
    cyc     = 0;
    while (fd_seen < 17 && cyc < 17 * NBITS * 434 + 500) begin
      @(negedge clk);
      cyc++;
      if (frame_done) begin
        if (fd_seen == 0) first_t = cyc;
        last_t = cyc;
        fd_seen++;
      end
      if (fd_seen < 17 && !ifc.busy) gaps++;
    end
    check("burst_frames", 128'(fd_seen), 128'd17);
    check("burst_span", 128'(last_t - first_t), 128'(16 * NBITS * 434));
    check("burst_idle_gaps", 128'(gaps), 128'd0);
    @(negedge clk);
    check("burst_sb_drained", 128'(exp_q.size()), 128'd0);
    check("burst_empty_after", 128'(ifc.fifo_empty), 128'd1);

    // Divisor change during DATA bit 3 of a div=7 frame; next byte uses div=1.
    set_div(16'd7);
    push_byte(8'h55, 1'b1);
    cap_a = '0; cap_b = '0; exp_a = '0; exp_b = '0;
    for (int i = 0; i < NBITS * 10 + 3; i++) begin
      @(negedge clk);
      if (i < NBITS * 8) begin
        cap_a[i] = tx;
        exp_a[i] = exp_bit(8'h55, 8, i);
      end else if (i < NBITS * 10) begin
        cap_b[i - NBITS * 8] = tx;
        exp_b[i - NBITS * 8] = exp_bit(8'h33, 2, i - NBITS * 8);
      end
      if (i == 34) begin
        ifc.div_we = 1'b1;
        ifc.div_in = 16'd1;
      end else if (i == 35) begin
        ifc.div_we  = 1'b0;
        ifc.data_we = 1'b1;
        ifc.data_in = 8'h33;
        exp_q.push_back(8'h33);
      end else if (i == 36) begin
        ifc.data_we = 1'b0;
      end
    end
    check("divchg_first_wave", cap_a, exp_a);
    check("divchg_second_wave", cap_b, exp_b);
    check("divchg_sb_drained", 128'(exp_q.size()), 128'd0);

    // Reset during DATA bit 4 with bytes still queued.
    set_div(16'd3);
    push_byte(8'h0F, 1'b0);
    ifc.data_we = 1'b1;
    ifc.data_in = 8'h11;
    @(negedge clk);
    ifc.data_in = 8'h22;
    @(negedge clk);
    ifc.data_we = 1'b0;
    repeat (20) @(negedge clk);
    check("rstmid_tx_bit4", 128'(tx), 128'd0);
    check("rstmid_queued", 128'(ifc.fifo_empty), 128'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_tx_async", 128'(tx), 128'd1);
    check("rstmid_busy_async", 128'(ifc.busy), 128'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_empty", 128'(ifc.fifo_empty), 128'd1);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || tx !== 1'b1 || ifc.busy !== 1'b0) bad++;
    end
    check("rstmid_no_activity", 128'(bad), 128'd0);

`ifdef UART_TX_PARITY_EN
    set_div(16'd1);
    send_and_check(8'h07, 2, "par07");
    send_and_check(8'h03, 2, "par03");
`endif

    repeat (5) @(negedge clk);
    check("final_sb_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
